// File: rtl/conv_pkg.sv
// Shared constants and window-packing helper for the 3x3 convolution datapath.
// The PE tensor imports the same constants so window widths always agree.
package conv_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_PIX = 9;
    localparam int WIN_W   = PIX_W * WIN_PIX;

    typedef logic [PIX_W-1:0] pixel_t;

    // One window column, indexed by row: [0] oldest row, [2] newest row.
    typedef logic [2:0][PIX_W-1:0] column_t;

    function automatic logic [WIN_W-1:0] pack_window(
        input column_t c0,
        input column_t c1,
        input column_t c2
    );
        logic [WIN_W-1:0] w;
        w = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            w[PIX_W*(3*r)   +: PIX_W] = c0[r];
            w[PIX_W*(3*r+1) +: PIX_W] = c1[r];
            w[PIX_W*(3*r+2) +: PIX_W] = c2[r];
        end
        return w;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: single port, combinational read of the old
// value at addr and a write of the new value on the same clock edge.
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(IMG_W)-1:0] addr,
    input  logic [PIX_W-1:0]         wr_data,
    output logic [PIX_W-1:0]         rd_data
);

    // Contents are never reset; the first two rows of a frame refill them.
    logic [PIX_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to 3x3 "valid" convolution windows, with two line
// buffers, a 3-column shift register and a valid/ready output register.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_window,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          accept;
    logic          complete;

    pixel_t        top_pix;
    pixel_t        mid_pix;
    column_t       new_col;
    column_t       win_c0;
    column_t       win_c1;
    column_t       win_c2;
    logic [WIN_W-1:0] next_window;

    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign complete = accept && (row >= RW'(2)) && (col >= CW'(2));

    // lb0 holds row-2, lb1 holds row-1; the row-1 pixel ages into lb0.
    line_buffer #(
        .IMG_W (IMG_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (mid_pix),
        .rd_data (top_pix)
    );

    line_buffer #(
        .IMG_W (IMG_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (in_pixel),
        .rd_data (mid_pix)
    );

    assign new_col     = {in_pixel, mid_pix, top_pix};
    assign next_window = pack_window(win_c1, win_c2, new_col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_c0 <= '0;
            win_c1 <= '0;
            win_c2 <= '0;
        end else if (accept) begin
            win_c0 <= win_c1;
            win_c1 <= win_c2;
            win_c2 <= new_col;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_last   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid  <= 1'b1;
            out_window <= next_window;
            out_last   <= row_last && col_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 4x4 image: fixed vector table, stall, clear and
// reset sequences, and gapped/random streams checked against an image-array model.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [7:0]  pix;
        logic        exp_valid;
        logic [71:0] exp_win;
        logic        exp_last;
    } vec_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             clear     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel  = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIN_W-1:0] out_window;
    logic             out_last;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the frame as a 2D image plus the expected output register.
    logic [7:0]  img [H][W];
    int          m_r;
    int          m_c;
    logic        m_valid;
    logic [71:0] m_win;
    logic        m_last;

    logic [71:0] dut_q [$];
    int          dut_lasts;
    logic [71:0] exp_w [4];
    vec_t        tbl [16];

    conv_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] window_at(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1; in_pixel = '0;
        #1;
        check("rst_out_valid", 72'(out_valid), 72'd0);
        check("rst_out_window", out_window, 72'd0);
        check("rst_out_last", 72'(out_last), 72'd0);
        check("rst_in_ready", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_valid = 1'b0; m_win = '0; m_last = 1'b0; m_r = 0; m_c = 0;
    endtask

    // Called just after a rising edge; leaves time just after the next one.
    task automatic drive_cycle(input logic v, input logic [7:0] p, input logic rdy,
                               input logic clr, output logic acc);
        logic m_ready;
        logic prev_valid;
        in_valid = v; in_pixel = p; out_ready = rdy; clear = clr;
        #1;
        m_ready = !clr && (!m_valid || rdy);
        check("in_ready", 72'(in_ready), 72'(m_ready));
        acc = v && m_ready;
        prev_valid = out_valid;
        @(posedge clk);
        #1;
        if (clr) begin
            m_valid = 1'b0; m_r = 0; m_c = 0;
        end else if (acc) begin
            img[m_r][m_c] = p;
            if (m_r >= 2 && m_c >= 2) begin
                m_valid = 1'b1;
                m_win   = window_at(m_r, m_c);
                m_last  = (m_r == H-1) && (m_c == W-1);
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (m_c == W-1) begin
                m_c = 0;
                m_r = (m_r == H-1) ? 0 : m_r + 1;
            end else begin
                m_c++;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        check("out_valid", 72'(out_valid), 72'(m_valid));
        if (m_valid) begin
            check("out_window", out_window, m_win);
            check("out_last", 72'(out_last), 72'(m_last));
        end
        if (out_valid && (!prev_valid || rdy)) begin
            dut_q.push_back(out_window);
            if (out_last) dut_lasts++;
        end
    endtask

    task automatic stream(input int first, input int last_p);
        logic acc;
        for (int p = first; p <= last_p; p++) drive_cycle(1'b1, 8'(p), 1'b1, 1'b0, acc);
    endtask

    task automatic check_frame_windows(input string name);
        check({name, "_count"}, 72'(dut_q.size()), 72'd4);
        for (int i = 0; i < 4; i++)
            check(name, (i < dut_q.size()) ? dut_q[i] : 72'd0, exp_w[i]);
    endtask

    // Feeds nframes with random gaps and random out_ready; pixel k of a frame is
    // k+1 unless rnd_pix, in which case pixels are random.
    task automatic run_frames(input int nframes, input logic rnd_pix);
        logic       acc;
        logic [7:0] p;
        int         tries;
        for (int k = 0; k < nframes*W*H; k++) begin
            p = rnd_pix ? 8'($urandom) : 8'((k % (W*H)) + 1);
            for (int g = $urandom_range(0, 3); g > 0; g--)
                drive_cycle(1'b0, 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, acc);
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 50) begin
                drive_cycle(1'b1, p, ($urandom_range(0, 3) != 0), 1'b0, acc);
                tries++;
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: pixel %0d not accepted within %0d cycles", k, tries);
            end
        end
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0, acc);
        drive_cycle(1'b0, 8'd0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        acc;
        int          psum;
        logic [71:0] filt;
        logic [71:0] held;

        exp_w[0] = 72'h0B0A09070605030201;
        exp_w[1] = 72'h0C0B0A080706040302;
        exp_w[2] = 72'h0F0E0D0B0A09070605;
        exp_w[3] = 72'h100F0E0C0B0A080706;
        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = 8'(i + 1);
            tbl[i].exp_valid = 1'b0;
            tbl[i].exp_win = '0;
            tbl[i].exp_last = 1'b0;
        end
        tbl[10] = '{8'h0B, 1'b1, exp_w[0], 1'b0};
        tbl[11] = '{8'h0C, 1'b1, exp_w[1], 1'b0};
        tbl[14] = '{8'h0F, 1'b1, exp_w[2], 1'b0};
        tbl[15] = '{8'h10, 1'b1, exp_w[3], 1'b1};

        #2;
        do_reset();

        // Gapless frame against the fixed table.
        dut_q.delete(); dut_lasts = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, tbl[i].pix, 1'b1, 1'b0, acc);
            check("tbl_valid", 72'(out_valid), 72'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check("tbl_window", out_window, tbl[i].exp_win);
                check("tbl_last", 72'(out_last), 72'(tbl[i].exp_last));
            end
        end
        check_frame_windows("gapless");
        check("gapless_lasts", 72'(dut_lasts), 72'd1);
        filt = 72'h010000000100000001;
        psum = 0;
        if (dut_q.size() > 0)
            for (int k = 0; k < 9; k++) psum += int'(dut_q[0][8*k +: 8]) * int'(filt[8*k +: 8]);
        check("pe_psum", 72'(psum), 72'd18);

        // Stall: hold out_ready low for 5 cycles after the first window.
        do_reset();
        stream(1, 11);
        held = out_window;
        for (int s = 0; s < 5; s++) begin
            drive_cycle(1'b1, 8'h0C, 1'b0, 1'b0, acc);
            check("stall_in_ready", 72'(in_ready), 72'd0);
            check("stall_window", out_window, held);
        end
        drive_cycle(1'b1, 8'h0C, 1'b1, 1'b0, acc);
        check("stall_release_window", out_window, exp_w[1]);
        check("stall_release_valid", 72'(out_valid), 72'd1);
        stream(13, 16);

        // Two back-to-back frames with gaps and backpressure.
        do_reset();
        dut_q.delete(); dut_lasts = 0;
        run_frames(2, 1'b0);
        check("gap_count", 72'(dut_q.size()), 72'd8);
        for (int i = 0; i < 8; i++)
            check("gap_window", (i < dut_q.size()) ? dut_q[i] : 72'd0, exp_w[i % 4]);
        check("gap_lasts", 72'(dut_lasts), 72'd2);

        // Random pixel values, checked by the model only.
        dut_lasts = 0;
        run_frames(1, 1'b1);
        check("rnd_lasts", 72'(dut_lasts), 72'd1);

        // Reset mid-frame after 7 pixels, then a full frame.
        stream(1, 7);
        do_reset();
        dut_q.delete();
        stream(1, 16);
        check_frame_windows("after_reset");

        // clear together with in_valid at pixel 9.
        do_reset();
        stream(1, 8);
        drive_cycle(1'b1, 8'h09, 1'b1, 1'b1, acc);
        check("clear_out_valid", 72'(out_valid), 72'd0);
        dut_q.delete();
        stream(1, 16);
        check_frame_windows("after_clear");

        // clear while a window is pending and out_ready is low.
        stream(1, 11);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("clear_valid_drop", 72'(out_valid), 72'd0);
        dut_q.delete();
        stream(1, 16);
        check_frame_windows("after_clear2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Upstream feeder for the 3x3 convolution PE tensor. It accepts a raster-order stream of 8-bit ifmap pixels and buffers the two previous image rows in line buffers. It emits one packed 72-bit 3x3 window per valid output position ("valid" convolution, no padding). Each window is held in an output register with a valid/ready handshake, so the downstream PE input can be driven directly.

## Interface
- IMG_W, default 8: image width in pixels, ≥3.
- IMG_H, default 8: image height in pixels, ≥3.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous frame restart; clears counters and out_valid.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pixel  in  8  unsigned ifmap pixel, raster order.
- out_valid  out  1  out_window holds a complete window.
- out_ready  in  1  downstream consumes out_window this cycle.
- out_window  out  72  packed window; byte k at [8k+7:8k], k = 3r+c.
- out_last  out  1  qualifies the final window of a frame.

## Operation
- An accept happens when in_valid && in_ready.
- in_ready = !clear && (!out_valid || out_ready). This is combinational, with no dependency on in_valid.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accept.
  - col wraps to 0 and row increments.
  - After (IMG_H-1, IMG_W-1), both wrap to 0 for the next frame.
- Line buffers lb0 holds row-2 and lb1 holds row-1, each IMG_W × 8.
  - On an accept at column col: top = lb0[col], mid = lb1[col] (read-before-write).
  - Then lb0[col] ← mid and lb1[col] ← in_pixel.
- The window shift register is 3 columns × 3 rows. On each accept, existing columns shift left and the new column {top, mid, in_pixel} enters at c=2.
- Packing: r=0 is the oldest row, c=0 the leftmost column. Byte 0 is (row-2, col-2); byte 8 is the pixel just accepted.
- A window is complete when an accept occurs with row ≥ 2 && col ≥ 2.
  - Columns 0 and 1 of each row never emit, because the shift register straddles a row boundary there.
- Output register update, priority high to low:
  1. clear → out_valid 0.
  2. Complete accept → out_valid 1, out_window and out_last loaded.
  3. out_ready → out_valid 0.
- out_last = 1 iff the loaded window is at (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_W-2)·(IMG_H-2).
- clear asserted together with in_valid: no accept; the pixel is not consumed.
- All arithmetic is pure data movement; pixels are not modified.

## Timing
- Reset values: out_valid 0, out_window 0, out_last 0, col 0, row 0, window register 0.
  - in_ready therefore reads 1 after reset.
  - Line buffer contents are unreset (don't-care, since rows 0–1 rewrite them before use).
- Latency: out_valid rises on the clock edge that performs the completing accept, i.e. 1 cycle after the pixel is presented.
- Throughput: 1 pixel/cycle while out_ready stays high.
- Stall: while out_valid && !out_ready:
  - out_window and out_last hold stable.
  - in_ready is 0.
  - No counter or buffer changes.
- Simultaneous consume and new complete window: the new window loads and out_valid stays 1.
- Reset mid-frame: all state returns to reset values asynchronously. The next accepted pixel is (0,0).

## Structure
- Shared package conv_pkg holds PIX_W = 8, WIN_PIX = 9 and WIN_W = 72. The PE tensor uses the same constants.
- Sub-module line_buffer: IMG_W-deep, 8-bit, single-port, read-before-write, address = col. Instantiate it twice (lb0, lb1).
- Counters, window shift register and output register live in the top module.

## Test plan
- IMG_W = IMG_H = 4, stream 0x01..0x10 with out_ready=1:
  - First out_valid comes after pixel 0x0B with out_window = 72'h0B0A09070605030201.
  - Exactly 4 windows; the last is 72'h100F0E0C0B0A080706 with out_last=1.
- Same stream, pixels fed to a PE loaded with filter 72'h010000000100000001 → first psum = 0x01+0x06+0x0B = 18.
- Hold out_ready=0 after the first window:
  - in_ready=0 and out_window stays stable for 5 cycles.
  - Release → the second window is 72'h0C0B0A080706040302.
- Random in_valid gaps of 0–3 cycles across two back-to-back frames → window values identical to the gapless run; out_last asserts once per frame.
- Drive rst=0 after 7 pixels, release, stream a full frame → exactly 4 windows, first = 72'h0B0A09070605030201.
- Assert clear together with in_valid at pixel 9 → that pixel is not accepted and out_valid=0. The restarted frame then produces the correct 4 windows.
